uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 14 +
 rtl/uart_tx_arb_rr_pick.sv | 25 ++
 rtl/uart_tx_arb.sv | 119 +++++++++++
 tb/tb_uart_tx_arb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared UART arbiter definitions: FSM encoding and default sizing.
// Reused by the RX-side controller.
package uart_tx_arb_pkg;

  localparam int UART_ARB_N    = 4;
  localparam int UART_ARB_IDXW = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index after i_last.
// Holds no state.
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    i_elig,
  input  logic [IDXW-1:0] i_last,
  output logic [IDXW-1:0] o_win,
  output logic            o_valid
);

  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    // Offset 1..N visits last+1 first and last itself at the end.
    for (int i = 1; i <= N; i++) begin
      if (!o_valid && i_elig[(int'(i_last) + i) % N]) begin
        o_valid = 1'b1;
        o_win   = IDXW'((int'(i_last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Multi-requester byte arbiter in front of uart_tx.
// Round-robin grant, optional frame lock, 4-phase start handshake.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N    = UART_ARB_N,
  parameter int IDXW = UART_ARB_IDXW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    REQ,
  input  logic [N-1:0]    LOCK,
  input  logic [8*N-1:0]  DATA,
  output logic [N-1:0]    DONE,
  output logic [IDXW-1:0] OWNER,
  output logic            BUSY,
  output logic [7:0]      TX_DATA,
  output logic            TX_START_REQ,
  input  logic            TX_START_ACK
);

  uart_arb_state_t r_state;
  logic [IDXW-1:0] r_owner;
  logic            r_lock;
  logic [7:0]      r_tx_data;
  logic            r_tx_req;
  logic [N-1:0]    r_done;
  logic            r_busy;

  logic [N-1:0]    w_own_oh;
  logic [N-1:0]    w_elig;
  logic            w_lock_eff;
  logic [IDXW-1:0] w_win;
  logic            w_valid;
  logic [7:0]      w_byte;
  logic            w_win_lock;

  always_comb begin
    w_own_oh          = '0;
    w_own_oh[r_owner] = 1'b1;
    // Lock lapses the moment the owner drops its LOCK bit.
    w_lock_eff = r_lock & LOCK[r_owner];
    w_elig     = w_lock_eff ? (REQ & w_own_oh) : REQ;
  end

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .i_elig  (w_elig),
    .i_last  (r_owner),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  always_comb begin
    w_byte     = '0;
    w_win_lock = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (IDXW'(k) == w_win) begin
        w_byte     = DATA[8*k +: 8];
        w_win_lock = LOCK[k];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_owner   <= IDXW'(N - 1);
      r_lock    <= 1'b0;
      r_tx_data <= '0;
      r_tx_req  <= 1'b0;
      r_done    <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= '0;
      r_lock <= w_lock_eff;
      case (r_state)
        ST_IDLE: begin
          // A stale ACK from a previous transfer blocks any new grant.
          if (!TX_START_ACK && w_valid) begin
            r_owner   <= w_win;
            r_tx_data <= w_byte;
            r_lock    <= w_win_lock;
            r_tx_req  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (TX_START_ACK) begin
            r_tx_req        <= 1'b0;
            r_done[r_owner] <= 1'b1;
            r_state         <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!TX_START_ACK) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx_req <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign DONE         = r_done;
  assign OWNER        = r_owner;
  assign BUSY         = r_busy;
  assign TX_DATA      = r_tx_data;
  assign TX_START_REQ = r_tx_req;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with hand-computed expectations.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_uart_tx_arb;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [3:0]  LOCK;
  logic [31:0] DATA;
  logic [3:0]  DONE;
  logic [1:0]  OWNER;
  logic        BUSY;
  logic [7:0]  TX_DATA;
  logic        TX_START_REQ;
  logic        TX_START_ACK;

  int total = 0;
  int bad   = 0;

  uart_tx_arb #(
    .N    (4),
    .IDXW (2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ          (REQ),
    .LOCK         (LOCK),
    .DATA         (DATA),
    .DONE         (DONE),
    .OWNER        (OWNER),
    .BUSY         (BUSY),
    .TX_DATA      (TX_DATA),
    .TX_START_REQ (TX_START_REQ),
    .TX_START_ACK (TX_START_ACK)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Wait for a grant, check it, then run the ACK handshake.
  task automatic serve(input string tag, input logic [1:0] own,
                       input logic [7:0] dat);
    int n;
    n = 0;
    while (!TX_START_REQ && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_grant"}, 32'(TX_START_REQ), 32'd1);
    chk({tag, "_owner"}, 32'(OWNER), 32'(own));
    chk({tag, "_data"}, 32'(TX_DATA), 32'(dat));
    chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    tick();
    tick();
    chk({tag, "_hold"}, 32'({TX_START_REQ, TX_DATA}), 32'({1'b1, dat}));
    TX_START_ACK = 1'b1;
    tick();
    chk({tag, "_reqlow"}, 32'(TX_START_REQ), 32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'(4'b0001 << own));
    TX_START_ACK = 1'b0;
    tick();
    chk({tag, "_done1cyc"}, 32'(DONE), 32'd0);
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    RST          = 1'b0;
    REQ          = '0;
    LOCK         = '0;
    DATA         = '0;
    TX_START_ACK = 1'b0;
    tick();
    do_reset();

    chk("rst_owner", 32'(OWNER), 32'd3);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_req", 32'(TX_START_REQ), 32'd0);
    chk("rst_data", 32'(TX_DATA), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);

    // Single requester, one-cycle grant latency, ACK 3 cycles later.
    REQ  = 4'b0001;
    DATA = 32'h0000_00A5;
    tick();
    chk("s1_lat", 32'(TX_START_REQ), 32'd1);
    REQ = 4'b0000;
    serve("s1", 2'd0, 8'hA5);
    tick();
    chk("s1_nogrant", 32'(TX_START_REQ), 32'd0);

    // Round-robin rotation from fresh reset.
    do_reset();
    DATA = 32'h4433_2211;
    REQ  = 4'b1111;
    serve("rr0", 2'd0, 8'h11);
    serve("rr1", 2'd1, 8'h22);
    serve("rr2", 2'd2, 8'h33);
    serve("rr3", 2'd3, 8'h44);
    serve("rr4", 2'd0, 8'h11);

    // Frame lock: requester 2 keeps ownership over requester 0.
    REQ  = 4'b0101;
    LOCK = 4'b0100;
    DATA = 32'h00C1_0099;
    serve("lk1", 2'd2, 8'hC1);
    DATA[23:16] = 8'hC2;
    serve("lk2", 2'd2, 8'hC2);
    DATA[23:16] = 8'hC3;
    serve("lk3", 2'd2, 8'hC3);
    REQ = 4'b0001;
    tick();
    tick();
    tick();
    chk("lk_starve", 32'(TX_START_REQ), 32'd0);
    LOCK = 4'b0000;
    serve("lk_rel", 2'd0, 8'h99);

    // Withdrawn request still completes; no repeat grant.
    REQ  = 4'b0010;
    DATA = 32'h0000_5A00;
    tick();
    tick();
    REQ = 4'b0000;
    serve("wd", 2'd1, 8'h5A);
    tick();
    tick();
    chk("wd_norepeat", 32'({BUSY, TX_START_REQ}), 32'd0);

    // Reset while in SEND abandons the byte.
    REQ  = 4'b0100;
    DATA = 32'h0077_0000;
    tick();
    chk("mr_send", 32'({TX_START_REQ, OWNER}), 32'({1'b1, 2'd2}));
    REQ = 4'b0000;
    RST = 1'b1;
    #1;
    chk("mr_async_req", 32'(TX_START_REQ), 32'd0);
    chk("mr_async_own", 32'(OWNER), 32'd3);
    tick();
    RST = 1'b0;
    tick();
    tick();
    chk("mr_nodone", 32'({DONE, BUSY}), 32'd0);
    REQ  = 4'b0001;
    DATA = 32'h0000_0042;
    serve("mr_next", 2'd0, 8'h42);
    REQ = 4'b0000;

    // Stuck ACK from reset blocks grants until it falls.
    TX_START_ACK = 1'b1;
    do_reset();
    REQ  = 4'b0010;
    DATA = 32'h0000_3C00;
    tick();
    tick();
    tick();
    chk("sa_block", 32'({BUSY, TX_START_REQ}), 32'd0);
    TX_START_ACK = 1'b0;
    tick();
    chk("sa_grant", 32'(TX_START_REQ), 32'd1);
    REQ = 4'b0000;
    serve("sa", 2'd1, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
